// File: rtl/dma_ram_rd_stream_pkg.sv
// Shared constants and state encoding for the DMA RAM read-stream initiator.
package dma_ram_rd_stream_pkg;

    localparam int unsigned SEG_COUNT_DEF      = 2;
    localparam int unsigned SEG_DATA_WIDTH_DEF = 128;
    localparam int unsigned SEG_ADDR_WIDTH_DEF = 8;
    localparam int unsigned SEG_BE_WIDTH_DEF   = SEG_DATA_WIDTH_DEF / 8;

    // One RAM word spans every segment; W bytes per stream beat.
    localparam int unsigned WORD_BYTES         = SEG_COUNT_DEF * SEG_BE_WIDTH_DEF;
    localparam int unsigned WORD_LOG2          = $clog2(WORD_BYTES);
    localparam int unsigned RAM_ADDR_WIDTH_DEF = SEG_ADDR_WIDTH_DEF + WORD_LOG2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/dma_ram_rd_stream_if.sv
// Segmented DMA RAM read port: per-segment command and response channels.
interface dma_ram_rd_stream_if
    import dma_ram_rd_stream_pkg::*;
#(
    parameter int unsigned SEG_COUNT      = SEG_COUNT_DEF,
    parameter int unsigned SEG_DATA_WIDTH = SEG_DATA_WIDTH_DEF,
    parameter int unsigned SEG_ADDR_WIDTH = SEG_ADDR_WIDTH_DEF
);

    logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr;
    logic [SEG_COUNT-1:0]                ram_rd_cmd_valid;
    logic [SEG_COUNT-1:0]                ram_rd_cmd_ready;
    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_rd_resp_data;
    logic [SEG_COUNT-1:0]                ram_rd_resp_valid;
    logic [SEG_COUNT-1:0]                ram_rd_resp_ready;

    modport master (
        output ram_rd_cmd_addr, ram_rd_cmd_valid, ram_rd_resp_ready,
        input  ram_rd_cmd_ready, ram_rd_resp_data, ram_rd_resp_valid
    );

    modport slave (
        input  ram_rd_cmd_addr, ram_rd_cmd_valid, ram_rd_resp_ready,
        output ram_rd_cmd_ready, ram_rd_resp_data, ram_rd_resp_valid
    );

endinterface

// File: rtl/dma_ram_rd_seg_fifo.sv
// Per-segment response FIFO; head entry is visible combinationally.
module dma_ram_rd_seg_fifo #(
    parameter int unsigned SEG_DATA_WIDTH = 128,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [SEG_DATA_WIDTH-1:0] push_data,
    input  logic                      pop,
    output logic [SEG_DATA_WIDTH-1:0] head_data,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [SEG_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic                      do_push, do_pop;

    // Extra pointer MSB separates full from empty.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        do_push   = push && !full;
        do_pop    = pop && !empty;
        wr_ptr_d  = wr_ptr_q + CNT_W'(do_push);
        rd_ptr_d  = rd_ptr_q + CNT_W'(do_pop);
        head_data = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dma_ram_rd_stream.sv
// Read initiator: turns a byte-range request into per-segment RAM reads and
// streams the returned words out one full RAM word per beat.
module dma_ram_rd_stream
    import dma_ram_rd_stream_pkg::*;
#(
    parameter int unsigned SEG_COUNT      = SEG_COUNT_DEF,
    parameter int unsigned SEG_DATA_WIDTH = SEG_DATA_WIDTH_DEF,
    parameter int unsigned SEG_ADDR_WIDTH = SEG_ADDR_WIDTH_DEF,
    parameter int unsigned SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
    parameter int unsigned RAM_ADDR_WIDTH = SEG_ADDR_WIDTH + $clog2(SEG_COUNT * SEG_BE_WIDTH),
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [RAM_ADDR_WIDTH-1:0]           req_addr,
    input  logic [LEN_WIDTH-1:0]                req_len,
    input  logic                                req_valid,
    output logic                                req_ready,
    output logic                                done,
    dma_ram_rd_stream_if.master                 ram,
    output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   m_axis_tkeep,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast
);

    localparam int unsigned W_BYTES = SEG_COUNT * SEG_BE_WIDTH;
    localparam int unsigned W_LOG2  = $clog2(W_BYTES);
    localparam int unsigned BEAT_W  = LEN_WIDTH - W_LOG2 + 1;
    localparam int unsigned CRED_W  = $clog2(FIFO_DEPTH + 1);

    state_e                    state_q, state_d;
    logic [SEG_ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
    logic [BEAT_W-1:0]         cmds_left_q, cmds_left_d;
    logic [BEAT_W-1:0]         beats_left_q, beats_left_d;
    logic [W_LOG2-1:0]         tail_q, tail_d;
    logic [SEG_COUNT-1:0]      seg_sent_q, seg_sent_d;
    logic [CRED_W-1:0]         credit_q [SEG_COUNT];
    logic [CRED_W-1:0]         credit_d [SEG_COUNT];
    logic                      done_q, done_d;
    logic                      req_ready_q, req_ready_d;

    logic [BEAT_W-1:0]         req_beats;
    logic [SEG_COUNT-1:0]      cmd_valid, cmd_hs;
    logic                      beat_hs;
    logic [SEG_COUNT-1:0]      fifo_empty;
    logic [SEG_COUNT-1:0]      unused_full;
    logic [SEG_DATA_WIDTH-1:0] fifo_head [SEG_COUNT];
    logic                      unused_addr_lo;

    assign unused_addr_lo        = ^req_addr[W_LOG2-1:0];
    assign req_ready             = req_ready_q;
    assign done                  = done_q;
    assign ram.ram_rd_cmd_addr   = {SEG_COUNT{word_addr_q}};
    assign ram.ram_rd_cmd_valid  = cmd_valid;
    assign ram.ram_rd_resp_ready = '1;
    assign cmd_hs                = cmd_valid & ram.ram_rd_cmd_ready;
    assign beat_hs               = m_axis_tvalid && m_axis_tready;
    assign req_beats             = BEAT_W'(req_len >> W_LOG2) + BEAT_W'(req_len[W_LOG2-1:0] != '0);

    for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
        dma_ram_rd_seg_fifo #(
            .SEG_DATA_WIDTH (SEG_DATA_WIDTH),
            .FIFO_DEPTH     (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (ram.ram_rd_resp_valid[n]),
            .push_data (ram.ram_rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
            .pop       (beat_hs),
            .head_data (fifo_head[n]),
            .empty     (fifo_empty[n]),
            .full      (unused_full[n])
        );
    end

    // Credits cap outstanding reads so a FIFO push always has room.
    always_comb begin
        for (int n = 0; n < SEG_COUNT; n++) begin
            cmd_valid[n] = (state_q == ST_ACTIVE) && (cmds_left_q != '0) &&
                           !seg_sent_q[n] && (credit_q[n] < CRED_W'(FIFO_DEPTH));
        end
    end

    always_comb begin
        m_axis_tvalid = (state_q == ST_ACTIVE) && (fifo_empty == '0);
        m_axis_tlast  = (beats_left_q == BEAT_W'(1));
        m_axis_tkeep  = '1;
        if (m_axis_tlast && (tail_q != '0)) begin
            m_axis_tkeep = W_BYTES'((W_BYTES'(1) << tail_q) - W_BYTES'(1));
        end
        for (int n = 0; n < SEG_COUNT; n++) begin
            m_axis_tdata[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = fifo_head[n];
        end
    end

    always_comb begin
        state_d      = state_q;
        word_addr_d  = word_addr_q;
        cmds_left_d  = cmds_left_q;
        beats_left_d = beats_left_q;
        tail_d       = tail_q;
        seg_sent_d   = seg_sent_q;
        done_d       = 1'b0;
        req_ready_d  = req_ready_q;

        if (state_q == ST_IDLE) begin
            if (req_valid) begin
                word_addr_d  = req_addr[RAM_ADDR_WIDTH-1:W_LOG2];
                tail_d       = req_len[W_LOG2-1:0];
                cmds_left_d  = req_beats;
                beats_left_d = req_beats;
                seg_sent_d   = '0;
                if (req_beats == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d     = ST_ACTIVE;
                    req_ready_d = 1'b0;
                end
            end
        end else begin
            // Word advances once every segment has taken it, this cycle included.
            seg_sent_d = seg_sent_q | cmd_hs;
            if (&seg_sent_d) begin
                seg_sent_d  = '0;
                word_addr_d = word_addr_q + SEG_ADDR_WIDTH'(1);
                cmds_left_d = cmds_left_q - BEAT_W'(1);
            end
            if (beat_hs) begin
                beats_left_d = beats_left_q - BEAT_W'(1);
                if (m_axis_tlast) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    req_ready_d = 1'b1;
                end
            end
        end

        for (int n = 0; n < SEG_COUNT; n++) begin
            credit_d[n] = credit_q[n] + CRED_W'(cmd_hs[n]) - CRED_W'(beat_hs);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_addr_q  <= '0;
            cmds_left_q  <= '0;
            beats_left_q <= '0;
            tail_q       <= '0;
            seg_sent_q   <= '0;
            credit_q     <= '{default: '0};
            done_q       <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            word_addr_q  <= word_addr_d;
            cmds_left_q  <= cmds_left_d;
            beats_left_q <= beats_left_d;
            tail_q       <= tail_d;
            seg_sent_q   <= seg_sent_d;
            credit_q     <= credit_d;
            done_q       <= done_d;
            req_ready_q  <= req_ready_d;
        end
    end

endmodule

// File: tb/tb_dma_ram_rd_stream.sv
// Bench for dma_ram_rd_stream: pipelined RAM model, randomized traffic and
// a transaction-level reference of expected beats and command gating.
module tb_dma_ram_rd_stream;

    localparam int unsigned RAW = 13;
    localparam int unsigned LW  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [RAW-1:0] req_addr;
    logic [LW-1:0]  req_len;
    logic           req_valid;
    logic           req_ready;
    logic           done;
    logic [255:0]   tdata;
    logic [31:0]    tkeep;
    logic           tvalid;
    logic           tready;
    logic           tlast;

    dma_ram_rd_stream_if #(.SEG_COUNT(2), .SEG_DATA_WIDTH(128), .SEG_ADDR_WIDTH(8)) ram_if ();

    dma_ram_rd_stream dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .done          (done),
        .ram           (ram_if),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- RAM model: 2-cycle read pipeline per segment ----------------
    logic [127:0]      ram_mem [2][256];
    logic [1:0]        s0_v, r_v;
    logic [7:0]        s0_a [2];
    logic [1:0][127:0] r_d;
    logic [1:0]        rdy_rand;
    int                stall1;
    int                rdy_mode = 0;
    int                tr_mode  = 0;
    int                cyc      = 0;

    assign ram_if.ram_rd_cmd_ready  = (rdy_mode == 0) ? 2'b11 :
                                      (rdy_mode == 1) ? {stall1 == 0, 1'b1} : rdy_rand;
    assign ram_if.ram_rd_resp_valid = r_v;
    assign ram_if.ram_rd_resp_data  = r_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v     <= '0;
            r_v      <= '0;
            stall1   <= 0;
            rdy_rand <= '1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                s0_v[n] <= ram_if.ram_rd_cmd_valid[n] && ram_if.ram_rd_cmd_ready[n];
                s0_a[n] <= ram_if.ram_rd_cmd_addr[n*8 +: 8];
                r_v[n]  <= s0_v[n];
                r_d[n]  <= ram_mem[n][s0_a[n]];
            end
            if (ram_if.ram_rd_cmd_valid[1] && ram_if.ram_rd_cmd_ready[1]) stall1 <= 3;
            else if (stall1 != 0) stall1 <= stall1 - 1;
            rdy_rand <= 2'($urandom);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (tr_mode)
            0:       tready <= 1'b1;
            1:       tready <= (cyc % 3 == 0);
            default: tready <= 1'($urandom);
        endcase
    end

    // ---------------- Reference model ----------------
    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    beat_t exp_q [$];
    beat_t bt;
    int    beat_cyc [$];
    int    cnt [2];
    int    beats, m_n, m_start, minc, nb, tl, wa;
    bit    m_active = 0, done_exp = 0, trace = 0, exp_v;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_active = 0;
            done_exp = 0;
            cnt[0]   = 0;
            cnt[1]   = 0;
            beats    = 0;
        end else begin
            check_eq("req_ready", req_ready, !m_active);
            check_eq("done", done, done_exp);
            check_eq("tvalid_unexpected", tvalid && (exp_q.size() == 0), 0);
            minc = (cnt[0] < cnt[1]) ? cnt[0] : cnt[1];
            for (int n = 0; n < 2; n++) begin
                exp_v = m_active && (cnt[n] < m_n) && (cnt[n] == minc) && (cnt[n] - beats < 4);
                check_eq("cmd_valid", ram_if.ram_rd_cmd_valid[n], exp_v);
                if (ram_if.ram_rd_cmd_valid[n])
                    check_eq("cmd_addr", ram_if.ram_rd_cmd_addr[n*8 +: 8], 256'((m_start + cnt[n]) % 256));
            end

            done_exp = 0;
            for (int n = 0; n < 2; n++)
                if (ram_if.ram_rd_cmd_valid[n] && ram_if.ram_rd_cmd_ready[n]) cnt[n]++;

            if (tvalid && tready) begin
                check_eq("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    bt = exp_q.pop_front();
                    check_eq("tdata", tdata, bt.data);
                    check_eq("tkeep", tkeep, bt.keep);
                    check_eq("tlast", tlast, bt.last);
                    beats++;
                    if (trace) beat_cyc.push_back(cyc);
                    if (bt.last) begin
                        m_active = 0;
                        done_exp = 1;
                    end
                end
            end

            if (req_valid && req_ready) begin
                nb = (int'(req_len) + 31) / 32;
                tl = int'(req_len) % 32;
                if (nb == 0) begin
                    done_exp = 1;
                end else begin
                    m_active = 1;
                    m_n      = nb;
                    m_start  = int'(req_addr) / 32;
                    cnt[0]   = 0;
                    cnt[1]   = 0;
                    beats    = 0;
                    for (int i = 0; i < nb; i++) begin
                        wa      = (m_start + i) % 256;
                        bt.data = {ram_mem[1][wa], ram_mem[0][wa]};
                        bt.last = (i == nb - 1);
                        for (int j = 0; j < 32; j++)
                            bt.keep[j] = !bt.last || (tl == 0) || (j < tl);
                        exp_q.push_back(bt);
                    end
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic do_req(input logic [RAW-1:0] a, input logic [LW-1:0] l);
        int k = 0;
        while (!req_ready && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("req_ready_timeout", k >= 1000, 0);
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((m_active || exp_q.size() != 0 || done_exp) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("idle_timeout", k >= budget, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_cmd_valid", ram_if.ram_rd_cmd_valid, 0);
        check_eq("rst_tvalid", tvalid, 0);
        check_eq("rst_tlast", tlast, 0);
        check_eq("rst_resp_ready", ram_if.ram_rd_resp_ready, 2'b11);
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++)
                ram_mem[s][a] = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Aligned 96-byte read with full throughput.
        trace = 1;
        do_req(13'h040, 16'd96);
        wait_idle(500);
        trace = 0;
        check_eq("beat_count", beat_cyc.size(), 3);
        for (int i = 1; i < beat_cyc.size(); i++)
            check_eq("beat_gap", beat_cyc[i] - beat_cyc[i-1], 1);

        do_req(13'h000, 16'd70);     // partial tail
        wait_idle(500);
        do_req(13'h123, 16'd0);      // empty request
        wait_idle(50);

        tr_mode = 1;                 // tready 1,0,0 back-pressure
        do_req(13'h000, 16'd320);
        wait_idle(2000);
        tr_mode = 0;

        rdy_mode = 1;                // slow segment 1
        do_req(13'h080, 16'd200);
        wait_idle(2000);
        rdy_mode = 0;

        do_req(13'h1FE0, 16'd64);    // word 255 wraps to 0
        wait_idle(500);

        for (int r = 0; r < 16; r++) begin
            tr_mode  = $urandom_range(0, 2);
            rdy_mode = $urandom_range(0, 2);
            do_req(13'($urandom), 16'($urandom_range(0, 400)));
            wait_idle(4000);
        end
        tr_mode  = 0;
        rdy_mode = 0;

        // Reset in the middle of a transfer.
        tr_mode = 1;
        do_req(13'h000, 16'd320);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        tr_mode = 0;
        @(posedge clk); #1;
        do_req(13'h100, 16'd100);
        wait_idle(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
